// File: rtl/digit_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// digit_rom_arbiter_if
// Purpose : bundles the requester-side lookup bus, the ROM-side address /
//           colour bus and the tagged response bus of the digit ROM arbiter.
// Signals :
//   req        N_REQ    per-requester lookup request (level)
//   req_x      6*N_REQ  column per requester, slice i = [6i+5:6i]
//   req_y      3*N_REQ  row per requester
//   req_a0     4*N_REQ  low BCD digit per requester
//   req_a1     4*N_REQ  high BCD digit per requester
//   gnt        N_REQ    one-hot accept
//   rom_x/y/a0/a1       registered ROM address
//   rom_color  12       colour returned by the ROM (1-cycle registered read)
//   rsp_valid  N_REQ    one-hot owner of rsp_color
//   rsp_color  12       returned pixel colour
//   rsp_err    1        accepted column was beyond the last glyph column
// Modports: slave = arbiter, master = requesters + ROM environment.
// ---------------------------------------------------------------------------
interface digit_rom_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [6*N_REQ-1:0] req_x;
    logic [3*N_REQ-1:0] req_y;
    logic [4*N_REQ-1:0] req_a0;
    logic [4*N_REQ-1:0] req_a1;
    logic [N_REQ-1:0]   gnt;
    logic [5:0]         rom_x;
    logic [2:0]         rom_y;
    logic [3:0]         rom_a0;
    logic [3:0]         rom_a1;
    logic [11:0]        rom_color;
    logic [N_REQ-1:0]   rsp_valid;
    logic [11:0]        rsp_color;
    logic               rsp_err;

    modport slave (
        input  req, req_x, req_y, req_a0, req_a1, rom_color,
        output gnt, rom_x, rom_y, rom_a0, rom_a1, rsp_valid, rsp_color, rsp_err
    );

    modport master (
        output req, req_x, req_y, req_a0, req_a1, rom_color,
        input  gnt, rom_x, rom_y, rom_a0, rom_a1, rsp_valid, rsp_color, rsp_err
    );
endinterface

// File: rtl/digit_rom_arbiter.sv
// ---------------------------------------------------------------------------
// digit_rom_arbiter
// Purpose : shares one two-digit glyph ROM (registered read) between N_REQ
//           pixel requesters. Round-robin arbitration, one lookup accepted per
//           cycle, fixed 2-cycle latency, responses tagged with a one-hot id.
// Ports   :
//   clk   in  system clock, all logic on posedge
//   rst   in  synchronous active-high reset
//   bus   slave modport of digit_rom_arbiter_if (request, ROM and response
//         buses, see the interface header)
// Parameters:
//   N_REQ      number of requesters (2..4)
//   X_MAX      last valid glyph column; larger columns flag rsp_err
//   BURST_LEN  max consecutive grants to one owner (burst build only)
// Build option:
//   DIGIT_ARB_BURST_EN  when defined, a requester that keeps req high keeps
//                       the grant for up to BURST_LEN transfers so a whole
//                       glyph row is scanned without interleaving. When not
//                       defined, arbitration is strict per-transfer
//                       round-robin.
// ---------------------------------------------------------------------------
module digit_rom_arbiter #(
    parameter int N_REQ = 2,
    parameter int X_MAX = 20
`ifdef DIGIT_ARB_BURST_EN
    ,
    parameter int BURST_LEN = 21
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_rom_arbiter_if.slave    bus
);

    // Round-robin position following requester i, wrapping N_REQ-1 -> 0.
    function automatic logic [1:0] ptr_after(input int i);
        return (i >= N_REQ - 1) ? 2'd0 : 2'(i + 1);
    endfunction

    logic [1:0]       rr_ptr_q,  rr_ptr_d;
    logic [5:0]       rom_x_q,   rom_x_d;
    logic [2:0]       rom_y_q,   rom_y_d;
    logic [3:0]       rom_a0_q,  rom_a0_d;
    logic [3:0]       rom_a1_q,  rom_a1_d;
    logic [N_REQ-1:0] s1_id_q,   s1_id_d;
    logic             s1_err_q,  s1_err_d;
    logic [N_REQ-1:0] s2_id_q,   s2_id_d;
    logic             s2_err_q,  s2_err_d;

`ifdef DIGIT_ARB_BURST_EN
    logic [4:0]       burst_cnt_q, burst_cnt_d;
    logic [1:0]       owner_q,     owner_d;
    logic             owner_req;
`endif

    logic [1:0]       search_start;
    logic [N_REQ-1:0] gnt_c;
    logic [N_REQ-1:0] gnt_o;
    logic             found;
    logic             xfer;
    int               acc_idx;
    logic [5:0]       sel_x;
    logic [2:0]       sel_y;
    logic [3:0]       sel_a0;
    logic [3:0]       sel_a1;

    // Grant selection: the first requesting slot found when walking from the
    // search start around the ring. In the burst build a locked owner that
    // still requests wins outright; a locked owner that dropped its request
    // hands the search start to the slot after it in the same cycle.
    always_comb begin
        search_start = rr_ptr_q;
        gnt_c        = '0;
        found        = 1'b0;
`ifdef DIGIT_ARB_BURST_EN
        owner_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i == int'(owner_q)) begin
                owner_req = bus.req[i];
            end
        end
        if (burst_cnt_q != 5'd0) begin
            search_start = ptr_after(int'(owner_q));
            if (owner_req) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == int'(owner_q)) begin
                        gnt_c[i] = 1'b1;
                    end
                end
                found = 1'b1;
            end
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && bus.req[i] &&
                    (i == ((int'(search_start) + k) % N_REQ))) begin
                    gnt_c[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    assign gnt_o   = rst ? '0 : gnt_c;
    assign bus.gnt = gnt_o;
    assign xfer    = |(bus.req & gnt_o);

    // Payload mux: pick the slice belonging to the granted requester.
    always_comb begin
        acc_idx = 0;
        sel_x   = '0;
        sel_y   = '0;
        sel_a0  = '0;
        sel_a1  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_o[i]) begin
                acc_idx = i;
                sel_x   = bus.req_x[6*i +: 6];
                sel_y   = bus.req_y[3*i +: 3];
                sel_a0  = bus.req_a0[4*i +: 4];
                sel_a1  = bus.req_a1[4*i +: 4];
            end
        end
    end

    // Next-state logic. The ROM address only moves on an accepted lookup so
    // the ROM never sees a spurious address on idle cycles; the id/err
    // pipeline clears stage 1 on idle cycles so no phantom response appears.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rom_x_d  = rom_x_q;
        rom_y_d  = rom_y_q;
        rom_a0_d = rom_a0_q;
        rom_a1_d = rom_a1_q;
        s1_id_d  = '0;
        s1_err_d = 1'b0;
        s2_id_d  = s1_id_q;
        s2_err_d = s1_err_q;
`ifdef DIGIT_ARB_BURST_EN
        burst_cnt_d = burst_cnt_q;
        owner_d     = owner_q;
        if ((burst_cnt_q != 5'd0) && !owner_req) begin
            burst_cnt_d = 5'd0;
            rr_ptr_d    = ptr_after(int'(owner_q));
        end
`endif
        if (xfer) begin
            rom_x_d  = sel_x;
            rom_y_d  = sel_y;
            rom_a0_d = sel_a0;
            rom_a1_d = sel_a1;
            s1_id_d  = gnt_o;
            s1_err_d = (int'(sel_x) > X_MAX);
`ifdef DIGIT_ARB_BURST_EN
            // The BURST_LEN-th transfer ends the burst; earlier ones extend it
            // and leave the round-robin pointer where it was.
            if (int'(burst_cnt_q) >= BURST_LEN - 1) begin
                burst_cnt_d = 5'd0;
                rr_ptr_d    = ptr_after(acc_idx);
            end else begin
                burst_cnt_d = burst_cnt_q + 5'd1;
                owner_d     = 2'(acc_idx);
            end
`else
            rr_ptr_d = ptr_after(acc_idx);
`endif
        end
    end

    // State registers; reset drops any in-flight lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            rom_x_q  <= '0;
            rom_y_q  <= '0;
            rom_a0_q <= '0;
            rom_a1_q <= '0;
            s1_id_q  <= '0;
            s1_err_q <= 1'b0;
            s2_id_q  <= '0;
            s2_err_q <= 1'b0;
`ifdef DIGIT_ARB_BURST_EN
            burst_cnt_q <= '0;
            owner_q     <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rom_x_q  <= rom_x_d;
            rom_y_q  <= rom_y_d;
            rom_a0_q <= rom_a0_d;
            rom_a1_q <= rom_a1_d;
            s1_id_q  <= s1_id_d;
            s1_err_q <= s1_err_d;
            s2_id_q  <= s2_id_d;
            s2_err_q <= s2_err_d;
`ifdef DIGIT_ARB_BURST_EN
            burst_cnt_q <= burst_cnt_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign bus.rom_x     = rom_x_q;
    assign bus.rom_y     = rom_y_q;
    assign bus.rom_a0    = rom_a0_q;
    assign bus.rom_a1    = rom_a1_q;
    assign bus.rsp_valid = s2_id_q;
    assign bus.rsp_err   = s2_err_q;
    assign bus.rsp_color = bus.rom_color;

endmodule
